keypad_encoder_sync: RTL and testbench

KEYPAD_ENCODER_SYNC -- requirements
Module: keypad_encoder_sync

---
 rtl/keypad_encoder_sync.sv | 125 ++++++++++++
 tb/tb_keypad_encoder_sync.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder_sync.sv
// Debounced keypad encoder: synchronises raw key lines, debounces press and
// release, and emits one load strobe (or an error pulse) per key press.
`timescale 1ns/1ps
module keypad_encoder_sync #(
  parameter int N_KEYS          = 10,
  parameter int DIGIT_W         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MODE            = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_KEYS-1:0]  keypad,
  input  logic               enablen,
  output logic [DIGIT_W-1:0] digit,
  output logic               loadn,
  output logic               error,
  output logic               busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_EMIT     = 3'd2;
  localparam logic [2:0] S_HELD     = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  logic [N_KEYS-1:0]  r_sync1;
  logic [N_KEYS-1:0]  r_ks;
  logic [N_KEYS-1:0]  r_snap;
  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT_W-1:0] r_digit;
  logic               r_loadn;
  logic               r_error;

  logic [DIGIT_W-1:0] w_code_tab [N_KEYS];
  logic [DIGIT_W-1:0] w_code;
  logic               w_valid;

  // Key b encodes as (N_KEYS - b) mod N_KEYS.
  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_code
    assign w_code_tab[gi] = (gi == 0) ? '0 : DIGIT_W'(N_KEYS - gi);
  end

  // Highest set bit of the snapshot; in strict mode only one bit may be set.
  always_comb begin
    w_code = '0;
    for (int b = 0; b < N_KEYS; b++) begin
      if (r_snap[b]) w_code = w_code_tab[b];
    end
    w_valid = (MODE != 0) || $onehot(r_snap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_ks    <= '0;
      r_snap  <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_digit <= '0;
      r_loadn <= 1'b1;
      r_error <= 1'b0;
    end else begin
      r_sync1 <= keypad;
      r_ks    <= r_sync1;
      r_loadn <= 1'b1;
      r_error <= 1'b0;
      if (enablen) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_ks != '0) begin
              r_state <= S_DEBOUNCE;
              r_snap  <= r_ks;
              r_cnt   <= '0;
            end
          end
          S_DEBOUNCE: begin
            if (r_ks != r_snap) begin
              r_state <= S_IDLE;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= S_EMIT;
              if (w_valid) begin
                r_digit <= w_code;
                r_loadn <= 1'b0;
              end else begin
                r_error <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_EMIT: r_state <= S_HELD;
          S_HELD: begin
            if (r_ks == '0) begin
              r_state <= S_RELEASE;
              r_cnt   <= '0;
            end
          end
          S_RELEASE: begin
            if (r_ks != '0) begin
              r_state <= S_HELD;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign digit = r_digit;
  assign loadn = r_loadn;
  assign error = r_error;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_keypad_encoder_sync.sv
// Scoreboard bench: strict (MODE 0) and priority (MODE 1) encoders share
// stimulus; expected strobes are queued per instance and matched by monitors.
`timescale 1ns/1ps
module tb_keypad_encoder_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] keypad = '0;
  logic       enablen = 1'b0;
  logic [3:0] digit0, digit1;
  logic       loadn0, loadn1, error0, error1, busy0, busy1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [3:0] digit;
    int         cyc;
  } ev_t;
  ev_t q0[$];
  ev_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_encoder_sync #(.N_KEYS(10), .DIGIT_W(4), .DEBOUNCE_CYCLES(4), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .keypad(keypad), .enablen(enablen),
    .digit(digit0), .loadn(loadn0), .error(error0), .busy(busy0)
  );

  keypad_encoder_sync #(.N_KEYS(10), .DIGIT_W(4), .DEBOUNCE_CYCLES(4), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .keypad(keypad), .enablen(enablen),
    .digit(digit1), .loadn(loadn1), .error(error1), .busy(busy1)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input bit err0, input int d0, input bit err1, input int d1,
                           input int at);
    q0.push_back('{err0, 4'(d0), at});
    q1.push_back('{err1, 4'(d1), at});
  endtask

  // Any loadn/error activity must match the head of the instance's queue.
  always @(negedge clk) begin
    if (!rst && (!loadn0 || error0)) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected: loadn=%0b error=%0b digit=%0d cyc=%0d", loadn0, error0, digit0, cyc);
      end else begin
        ev_t e;
        e = q0.pop_front();
        if (error0 != e.is_err || loadn0 != e.is_err || digit0 != e.digit || cyc != e.cyc) begin
          errors++;
          $display("FAIL dut0_event: got error=%0b loadn=%0b digit=%0d cyc=%0d, want error=%0b loadn=%0b digit=%0d cyc=%0d",
                   error0, loadn0, digit0, cyc, e.is_err, e.is_err, e.digit, e.cyc);
        end else begin
          $display("dut0 event ok: error=%0b digit=%0d cyc=%0d", error0, digit0, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (!loadn1 || error1)) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected: loadn=%0b error=%0b digit=%0d cyc=%0d", loadn1, error1, digit1, cyc);
      end else begin
        ev_t e;
        e = q1.pop_front();
        if (error1 != e.is_err || loadn1 != e.is_err || digit1 != e.digit || cyc != e.cyc) begin
          errors++;
          $display("FAIL dut1_event: got error=%0b loadn=%0b digit=%0d cyc=%0d, want error=%0b loadn=%0b digit=%0d cyc=%0d",
                   error1, loadn1, digit1, cyc, e.is_err, e.is_err, e.digit, e.cyc);
        end else begin
          $display("dut1 event ok: error=%0b digit=%0d cyc=%0d", error1, digit1, cyc);
        end
      end
    end
  end

  task automatic drain(input string name);
    tick(2);
    chk({name, "_q0_empty"}, q0.size(), 0);
    chk({name, "_q1_empty"}, q1.size(), 0);
  endtask

  initial begin
    int c;
    // Reset values
    tick(3);
    chk("rst_digit0", digit0, 0);
    chk("rst_loadn0", loadn0, 1);
    chk("rst_error0", error0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    tick(3);

    // Single key, bit 6 -> digit 4, strobe at edge 7; busy until release completes
    keypad = 10'b0001000000;
    c = cyc;
    expect_ev(0, 4, 0, 4, c + 7);
    tick(10);
    chk("held_busy0", busy0, 1);
    keypad = '0;
    c = cyc;
    tick(5);
    chk("release_busy0", busy0, 1);
    tick(3);
    chk("idle_busy0", busy0, 0);
    chk("idle_busy1", busy1, 0);
    drain("single");

    // Bouncing key 5, then stable: one strobe, 7 edges after the last toggle
    for (int i = 0; i < 6; i++) begin
      keypad = (i % 2 == 0) ? 10'b0000100000 : 10'b0;
      tick(2);
    end
    keypad = 10'b0000100000;
    c = cyc;
    expect_ev(0, 5, 0, 5, c + 7);
    tick(12);
    keypad = '0;
    tick(12);
    drain("bounce");

    // Two keys: strict mode errors (digit held at 5), priority mode picks bit 9
    keypad = 10'b1000000100;
    c = cyc;
    expect_ev(1, 5, 0, 1, c + 7);
    tick(12);
    chk("multi_digit0", digit0, 5);
    chk("multi_digit1", digit1, 1);
    keypad = '0;
    tick(12);
    drain("multi");

    // enablen raised mid-debounce aborts; lowering it with key held restarts
    keypad = 10'b0000001000;
    tick(4);
    chk("deb_busy0", busy0, 1);
    enablen = 1'b1;
    tick(1);
    chk("dis_busy0", busy0, 0);
    chk("dis_busy1", busy1, 0);
    tick(3);
    chk("dis_hold_busy0", busy0, 0);
    enablen = 1'b0;
    c = cyc;
    expect_ev(0, 7, 0, 7, c + 5);
    tick(10);
    keypad = '0;
    tick(12);
    drain("enable");

    // Long hold, short release (no strobe), long release then re-press
    keypad = 10'b0100000000;
    c = cyc;
    expect_ev(0, 2, 0, 2, c + 7);
    tick(50);
    keypad = '0;
    tick(2);
    keypad = 10'b0100000000;
    tick(10);
    keypad = '0;
    tick(10);
    keypad = 10'b0100000000;
    c = cyc;
    expect_ev(0, 2, 0, 2, c + 7);
    tick(12);
    drain("hold");

    // Reset in HELD: immediate reset outputs, then held key is a new press
    chk("pre_rst_busy0", busy0, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy0", busy0, 0);
    chk("arst_digit0", digit0, 0);
    chk("arst_loadn1", loadn1, 1);
    chk("arst_digit1", digit1, 0);
    tick(2);
    rst = 1'b0;
    c = cyc;
    expect_ev(0, 2, 0, 2, c + 7);
    tick(12);
    keypad = '0;
    tick(12);
    drain("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
